// File: rtl/pll_phase_ctrl.sv
// Dynamic phase-shift sequencer for the PLL PSSEL/PSDIR/PSPULSE port.
// Ports: clk/resetn, pll_lock (async), cmd_* step command handshake,
//   done/err status, pssel/psdir/pspulse to the PLL,
//   phase_sel/phase_pos per-channel read-back, rst_out_n lock-gated reset.
module pll_phase_ctrl #(
    parameter int SETUP_CYC    = 4,
    parameter int PULSE_HI_CYC = 4,
    parameter int PULSE_LO_CYC = 4,
    parameter int SETTLE_CYC   = 16,
    parameter int LOCK_CYC     = 1024,
    parameter int STEP_W       = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              pll_lock,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_sel,
    input  logic              cmd_dir,
    input  logic [STEP_W-1:0] cmd_steps,
    output logic              done,
    output logic              err,
    output logic [2:0]        pssel,
    output logic              psdir,
    output logic              pspulse,
    input  logic [2:0]        phase_sel,
    output logic [STEP_W-1:0] phase_pos,
    output logic              rst_out_n
);

    localparam int M0 = (SETUP_CYC > PULSE_HI_CYC) ?
                        SETUP_CYC : PULSE_HI_CYC;
    localparam int M1 = (M0 > PULSE_LO_CYC) ? M0 : PULSE_LO_CYC;
    localparam int M2 = (M1 > SETTLE_CYC) ? M1 : SETTLE_CYC;
    localparam int MX = (M2 > LOCK_CYC) ? M2 : LOCK_CYC;
    localparam int CW = $clog2(MX) + 1;

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] HI_LAST    = CW'(PULSE_HI_CYC - 1);
    localparam logic [CW-1:0] LO_LAST    = CW'(PULSE_LO_CYC - 1);
    localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE_CYC);
    localparam logic [CW-1:0] LOCK_MAX   = CW'(LOCK_CYC);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

    typedef enum logic [2:0] {
        S_WAIT_LOCK,
        S_IDLE,
        S_SETUP,
        S_PHI,
        S_PLO,
        S_SETTLE
    } state_t;

    state_t            state;
    logic              lock_s1;
    logic              lock_s2;
    logic [CW-1:0]     lock_cnt;
    logic              lock_ok;
    logic [CW-1:0]     cyc;
    logic [STEP_W-1:0] rem;
    logic [2:0]        sel_q;
    logic              dir_q;
    logic              busy;
    logic              handshake;
    logic [STEP_W-1:0] acc [8];

    // Two-flop synchroniser plus saturating stable-lock counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_s1   <= 1'b0;
            lock_s2   <= 1'b0;
            lock_cnt  <= '0;
            rst_out_n <= 1'b0;
        end else begin
            lock_s1 <= pll_lock;
            lock_s2 <= lock_s1;
            if (!lock_s2) begin
                lock_cnt <= '0;
            end else if (lock_cnt != LOCK_MAX) begin
                lock_cnt <= lock_cnt + CNT_ONE;
            end
            rst_out_n <= lock_s2 & lock_ok;
        end
    end

    assign lock_ok   = (lock_cnt == LOCK_MAX);
    assign cmd_ready = (state == S_IDLE) & lock_ok & lock_s2;
    assign handshake = cmd_valid & cmd_ready;
    assign busy      = (state == S_SETUP) | (state == S_PHI) |
                       (state == S_PLO) | (state == S_SETTLE);

    // Channel 7 has no accumulator writer, so it reads back as zero.
    assign phase_pos = acc[phase_sel];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_WAIT_LOCK;
            cyc     <= '0;
            rem     <= '0;
            sel_q   <= '0;
            dir_q   <= 1'b0;
            pssel   <= '0;
            psdir   <= 1'b0;
            pspulse <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                acc[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (busy && !lock_s2) begin
                // Abort: counted steps stay in the accumulator.
                pspulse <= 1'b0;
                err     <= 1'b1;
                done    <= 1'b1;
                cyc     <= '0;
                state   <= S_WAIT_LOCK;
            end else begin
                unique case (state)
                    S_WAIT_LOCK: begin
                        if (lock_ok && lock_s2) begin
                            state <= S_IDLE;
                        end
                    end
                    S_IDLE: begin
                        if (!lock_s2) begin
                            state <= S_WAIT_LOCK;
                        end else if (handshake) begin
                            sel_q <= cmd_sel;
                            dir_q <= cmd_dir;
                            rem   <= cmd_steps;
                            pssel <= cmd_sel;
                            psdir <= cmd_dir;
                            cyc   <= '0;
                            if (cmd_sel == 3'd7) begin
                                err  <= 1'b1;
                                done <= 1'b1;
                            end else if (cmd_steps == '0) begin
                                state <= S_SETTLE;
                            end else begin
                                state <= S_SETUP;
                            end
                        end
                    end
                    S_SETUP: begin
                        if (cyc == SETUP_LAST) begin
                            cyc     <= '0;
                            pspulse <= 1'b1;
                            state   <= S_PHI;
                        end else begin
                            cyc <= cyc + CNT_ONE;
                        end
                    end
                    S_PHI: begin
                        if (cyc == HI_LAST) begin
                            // Falling edge of PSPULSE is the step.
                            cyc     <= '0;
                            pspulse <= 1'b0;
                            rem     <= rem - STEP_ONE;
                            if (dir_q) begin
                                acc[sel_q] <= acc[sel_q] + STEP_ONE;
                            end else begin
                                acc[sel_q] <= acc[sel_q] - STEP_ONE;
                            end
                            state <= S_PLO;
                        end else begin
                            cyc <= cyc + CNT_ONE;
                        end
                    end
                    S_PLO: begin
                        if (cyc == LO_LAST) begin
                            cyc <= '0;
                            if (rem != '0) begin
                                pspulse <= 1'b1;
                                state   <= S_PHI;
                            end else begin
                                state <= S_SETTLE;
                            end
                        end else begin
                            cyc <= cyc + CNT_ONE;
                        end
                    end
                    S_SETTLE: begin
                        if (cyc == SETTLE_END) begin
                            cyc   <= '0;
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            cyc <= cyc + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= S_WAIT_LOCK;
                    end
                endcase
            end
        end
    end

endmodule
